// File: rtl/pong_pkg.sv
// Shared types and constants for the Pong game-flow blocks.
// Contents:
//   match_state_t           - match sequencer state encoding (3-bit)
//   SCORE_W / SCORE_MAX     - score width and saturation value
//   DIR_LEFT / DIR_RIGHT    - serve direction encodings
//   score_inc()             - saturating score increment
package pong_pkg;

  localparam int SCORE_W = 4;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 4'd15;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SERVE_WAIT  = 3'd1,
    ST_RALLY       = 3'd2,
    ST_POINT_PAUSE = 3'd3,
    ST_GAME_OVER   = 3'd4
  } match_state_t;

  // Scores stick at SCORE_MAX rather than wrapping to zero.
  function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] s);
    return (s == SCORE_MAX) ? s : s + 1'b1;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator.
// Ports:
//   clk_0 - system clock
//   rst   - synchronous active-high reset
//   clr   - synchronous restart of the prescaler (count returns to 0)
//   tick  - one-cycle pulse when the prescaler wraps (every CLK_FREQ_HZ/1000 cycles)
module ms_tick_gen #(
  parameter int CLK_FREQ_HZ = 25_175_000
) (
  input  logic clk_0,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV   = (CLK_FREQ_HZ / 1000 < 1) ? 1 : CLK_FREQ_HZ / 1000;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_0) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == CNT_LAST);

endmodule

// File: rtl/match_controller.sv
// Pong match sequencer: owns match state, both scores, serve timing and
// game-over detection. Gates ball motion and drives the AI opponent's
// reset_game / sq_missed inputs.
// Ports:
//   clk_0, rst              - clock, synchronous active-high reset
//   start_btn               - synchronised start button (rising edge used)
//   miss_left, miss_right   - ball left the field on that side (RALLY only)
//   score_p1, score_p2      - 4-bit saturating scores
//   reset_game, sq_missed   - recentre request / rally-over flag
//   ball_enable             - ball may move
//   serve_launch, serve_dir - one-cycle serve pulse and its direction
//   game_over, winner       - match finished, winner (0 = P1, 1 = P2)
// Build option: define MATCH_WIN_BY_TWO_EN to require a two-point lead to win.
module match_controller
  import pong_pkg::*;
#(
  parameter int CLK_FREQ_HZ    = 25_175_000,
  parameter int WIN_SCORE      = 11,
  parameter int SERVE_DELAY_MS = 1000,
  parameter int POINT_PAUSE_MS = 750
) (
  input  logic               clk_0,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               miss_left,
  input  logic               miss_right,
  output logic [SCORE_W-1:0] score_p1,
  output logic [SCORE_W-1:0] score_p2,
  output logic               reset_game,
  output logic               sq_missed,
  output logic               ball_enable,
  output logic               serve_launch,
  output logic               serve_dir,
  output logic               game_over,
  output logic               winner
);

  localparam int MS_MAX = (SERVE_DELAY_MS > POINT_PAUSE_MS) ? SERVE_DELAY_MS : POINT_PAUSE_MS;
  localparam int MS_W   = $clog2(MS_MAX + 2);
  localparam logic [MS_W-1:0]    SERVE_MS = MS_W'(SERVE_DELAY_MS);
  localparam logic [MS_W-1:0]    PAUSE_MS = MS_W'(POINT_PAUSE_MS);
  localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

  match_state_t    state;
  logic            start_q;
  logic            start_edge;
  logic            any_miss;
  logic            tick;
  logic            state_chg;
  logic            match_end;
  logic            p2_wins;
  logic [MS_W-1:0] ms_cnt;

  assign start_edge = start_btn & ~start_q;
  assign any_miss   = miss_left | miss_right;

  // Flags the cycle whose clock edge changes state, so the prescaler and the
  // ms counter both start from zero on the first cycle of the new state.
  always_comb begin
    state_chg = 1'b0;
    unique case (state)
      ST_IDLE:        state_chg = start_edge;
      ST_SERVE_WAIT:  state_chg = (ms_cnt == SERVE_MS);
      ST_RALLY:       state_chg = any_miss;
      ST_POINT_PAUSE: state_chg = (ms_cnt == PAUSE_MS);
      ST_GAME_OVER:   state_chg = start_edge;
      default:        state_chg = 1'b0;
    endcase
  end

  ms_tick_gen #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_ms_tick (
    .clk_0(clk_0),
    .rst  (rst),
    .clr  (state_chg),
    .tick (tick)
  );

`ifdef MATCH_WIN_BY_TWO_EN
  logic       last_let;
  logic [4:0] p1_ext;
  logic [4:0] p2_ext;

  // Remembers whether the rally that led into the current pause was a let;
  // a saturated 15:15 tie is only broken off after such a pause.
  always_ff @(posedge clk_0) begin
    if (rst) begin
      last_let <= 1'b0;
    end else if (state == ST_RALLY && any_miss) begin
      last_let <= miss_left & miss_right;
    end
  end

  assign p1_ext = {1'b0, score_p1};
  assign p2_ext = {1'b0, score_p2};

  always_comb begin
    match_end = ((score_p1 >= WIN) && (p1_ext >= p2_ext + 5'd2)) ||
                ((score_p2 >= WIN) && (p2_ext >= p1_ext + 5'd2)) ||
                (((score_p1 == SCORE_MAX) || (score_p2 == SCORE_MAX)) && (score_p1 != score_p2)) ||
                ((score_p1 == SCORE_MAX) && (score_p2 == SCORE_MAX) && last_let);
    p2_wins   = (score_p2 > score_p1);
  end
`else
  always_comb begin
    match_end = (score_p1 >= WIN) || (score_p2 >= WIN);
    p2_wins   = (score_p2 >= WIN);
  end
`endif

  always_ff @(posedge clk_0) begin
    if (rst) begin
      state        <= ST_IDLE;
      score_p1     <= '0;
      score_p2     <= '0;
      reset_game   <= 1'b1;
      sq_missed    <= 1'b0;
      ball_enable  <= 1'b0;
      serve_launch <= 1'b0;
      serve_dir    <= DIR_LEFT;
      game_over    <= 1'b0;
      winner       <= 1'b0;
      start_q      <= 1'b0;
      ms_cnt       <= '0;
    end else begin
      start_q      <= start_btn;
      serve_launch <= 1'b0;

      if (state_chg) begin
        ms_cnt <= '0;
      end else if (tick && ms_cnt != '1) begin
        ms_cnt <= ms_cnt + 1'b1;
      end

      unique case (state)
        ST_IDLE: begin
          reset_game  <= 1'b1;
          ball_enable <= 1'b0;
          if (start_edge) begin
            state     <= ST_SERVE_WAIT;
            score_p1  <= '0;
            score_p2  <= '0;
            serve_dir <= DIR_RIGHT;
          end
        end

        ST_SERVE_WAIT: begin
          // reset_game was raised on the way in, so it lasts one cycle.
          reset_game  <= 1'b0;
          ball_enable <= 1'b0;
          if (ms_cnt == SERVE_MS) begin
            state        <= ST_RALLY;
            serve_launch <= 1'b1;
            ball_enable  <= 1'b1;
          end
        end

        ST_RALLY: begin
          ball_enable <= 1'b1;
          if (any_miss) begin
            if (miss_left && !miss_right) begin
              score_p2  <= score_inc(score_p2);
              serve_dir <= DIR_LEFT;
            end else if (miss_right && !miss_left) begin
              score_p1  <= score_inc(score_p1);
              serve_dir <= DIR_RIGHT;
            end
            state       <= ST_POINT_PAUSE;
            ball_enable <= 1'b0;
            sq_missed   <= 1'b1;
          end
        end

        ST_POINT_PAUSE: begin
          ball_enable <= 1'b0;
          if (ms_cnt == PAUSE_MS) begin
            sq_missed  <= 1'b0;
            reset_game <= 1'b1;
            if (match_end) begin
              state     <= ST_GAME_OVER;
              game_over <= 1'b1;
              winner    <= p2_wins;
            end else begin
              state <= ST_SERVE_WAIT;
            end
          end
        end

        ST_GAME_OVER: begin
          reset_game  <= 1'b1;
          ball_enable <= 1'b0;
          if (start_edge) begin
            state     <= ST_SERVE_WAIT;
            score_p1  <= '0;
            score_p2  <= '0;
            game_over <= 1'b0;
            winner    <= 1'b0;
            serve_dir <= DIR_RIGHT;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Directed bench for match_controller with a 4-cycle millisecond,
// WIN_SCORE = 3, SERVE_DELAY_MS = 2 and POINT_PAUSE_MS = 1.
module tb_match_controller;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b1;
  logic       start_btn = 1'b0;
  logic       miss_left = 1'b0;
  logic       miss_right = 1'b0;
  logic [3:0] score_p1;
  logic [3:0] score_p2;
  logic       reset_game;
  logic       sq_missed;
  logic       ball_enable;
  logic       serve_launch;
  logic       serve_dir;
  logic       game_over;
  logic       winner;

  int checks = 0;
  int errors = 0;

  match_controller #(
    .CLK_FREQ_HZ   (4000),
    .WIN_SCORE     (3),
    .SERVE_DELAY_MS(2),
    .POINT_PAUSE_MS(1)
  ) dut (
    .clk_0       (clk_0),
    .rst         (rst),
    .start_btn   (start_btn),
    .miss_left   (miss_left),
    .miss_right  (miss_right),
    .score_p1    (score_p1),
    .score_p2    (score_p2),
    .reset_game  (reset_game),
    .sq_missed   (sq_missed),
    .ball_enable (ball_enable),
    .serve_launch(serve_launch),
    .serve_dir   (serve_dir),
    .game_over   (game_over),
    .winner      (winner)
  );

  always #5 clk_0 = ~clk_0;

  // One cycle of stimulus plus the output vector expected after that edge.
  // Packed output order: p1, p2, reset_game, sq_missed, ball_enable,
  // serve_launch, serve_dir, game_over, winner.
  typedef struct {
    logic        st;
    logic        ml;
    logic        mr;
    logic [14:0] exp;
  } vec_t;

  localparam int NVEC = 18;
  vec_t tbl[NVEC];

  function automatic vec_t mk(input logic st, ml, mr, input logic [3:0] p1, p2,
                              input logic rg, sq, be, sl, sd, go, wn);
    vec_t v;
    v.st  = st;
    v.ml  = ml;
    v.mr  = mr;
    v.exp = {p1, p2, rg, sq, be, sl, sd, go, wn};
    return v;
  endfunction

  function automatic logic [14:0] outs();
    return {score_p1, score_p2, reset_game, sq_missed, ball_enable,
            serve_launch, serve_dir, game_over, winner};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input logic s, input logic ml, input logic mr);
    start_btn  = s;
    miss_left  = ml;
    miss_right = mr;
    @(posedge clk_0);
    #1;
  endtask

  // Called on the SERVE_WAIT entry cycle; the launch should appear 9 cycles on.
  task automatic wait_launch(input logic dir);
    int n;
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end while (!serve_launch && n < 40);
    chk("launch_delay", n, 9);
    chk("launch_dir", serve_dir, dir);
    chk("launch_ball_en", ball_enable, 1);
  endtask

  // Called on the POINT_PAUSE entry cycle; sq_missed should last 5 cycles.
  task automatic wait_pause();
    int n;
    n = 0;
    do begin
      step(1'b0, 1'b0, 1'b0);
      n++;
    end while (sq_missed && n < 40);
    chk("pause_len", n, 5);
  endtask

  localparam logic [14:0] RST_VEC = 15'b0000_0000_1_0_0_0_0_0_0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = mk(0, 1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);  // misses ignored in IDLE
    tbl[1]  = mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0);  // start -> SERVE_WAIT entry
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);  // start ignored in SERVE_WAIT
    tbl[4]  = mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);  // miss ignored in SERVE_WAIT
    for (int i = 5; i <= 9; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);  // launch, 9 cycles after entry
    tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    tbl[12] = mk(0, 0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 0);  // miss_right -> P1 point
    tbl[13] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    tbl[14] = mk(0, 1, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);  // miss ignored in pause
    tbl[15] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    tbl[16] = mk(0, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0);
    tbl[17] = mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 0, 0);  // back to SERVE_WAIT

    // Reset, with a start edge coincident with rst that must be lost.
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("reset_state", outs(), RST_VEC);
    rst = 1'b0;
    step(1'b0, 1'b0, 1'b0);
    chk("start_with_rst_lost", outs(), RST_VEC);

    for (int i = 0; i < NVEC; i++) begin
      step(tbl[i].st, tbl[i].ml, tbl[i].mr);
      chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
    end

    // Let: both misses together.
    wait_launch(1'b1);
    step(1'b0, 1'b1, 1'b1);
    chk("let_scores", {score_p1, score_p2}, {4'd1, 4'd0});
    chk("let_pause", sq_missed, 1);
    wait_pause();
    chk("let_reserve_rg", reset_game, 1);
    chk("let_dir", serve_dir, 1);

`ifndef MATCH_WIN_BY_TWO_EN
    // Three P2 points end the match.
    wait_launch(1'b1);
    for (int k = 1; k <= 3; k++) begin
      step(1'b0, 1'b1, 1'b0);
      chk($sformatf("p2_point%0d", k), score_p2, k);
      chk($sformatf("p2_dir%0d", k), serve_dir, 0);
      wait_pause();
      if (k < 3) begin
        chk($sformatf("no_game_over%0d", k), game_over, 0);
        wait_launch(1'b0);
      end
    end
    chk("go_flags", {game_over, winner, reset_game, ball_enable}, 4'b1110);
    chk("go_scores", {score_p1, score_p2}, {4'd1, 4'd3});
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b0);
    chk("go_hold", {score_p1, score_p2, game_over}, {4'd1, 4'd3, 1'b1});
    step(1'b1, 1'b0, 1'b0);
    chk("restart", {score_p1, score_p2, game_over, reset_game, serve_dir},
        {4'd0, 4'd0, 1'b0, 1'b1, 1'b1});

    // rst in the middle of a point pause.
    wait_launch(1'b1);
    step(1'b0, 1'b0, 1'b1);
    chk("pre_rst_point", score_p1, 1);
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    chk("rst_mid_pause", outs(), RST_VEC);
`else
    // Win by two: points P1,P2,P2,P1,P2 reach 3:3 from 1:0, then P1 twice.
    begin
      logic pts[7];
      logic dir;
      int   p1;
      int   p2;
      pts = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};  // 1 = P2 scores
      dir = 1'b1;
      p1  = 1;
      p2  = 0;
      for (int k = 0; k < 7; k++) begin
        wait_launch(dir);
        step(1'b0, pts[k], ~pts[k]);
        if (pts[k]) p2++; else p1++;
        dir = ~pts[k];
        chk($sformatf("w2_score%0d", k), {score_p1, score_p2}, {p1[3:0], p2[3:0]});
        wait_pause();
        chk($sformatf("w2_go%0d", k), game_over, (k == 6));
      end
      chk("w2_winner", winner, 0);
      chk("w2_final", {score_p1, score_p2}, {4'd5, 4'd3});
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
